// File: rtl/task_scheduler.sv
// Scan-cycle sequencer and circular task FIFO feeding bit_cpu.
// Sequences IDLE -> RUN -> IO -> RUN/IDLE; watchdog and queue overflow force a sticky FAULT.
module task_scheduler #(
    parameter int IA_W    = 12,
    parameter int Q_DEPTH = 8,
    parameter int IO_CYC  = 4,
    parameter int WDT_MAX = 4095
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       START,
    input  logic                       STOP,
    input  logic                       FAULT_ACK,
    input  logic [IA_W-1:0]            T_DI,
    input  logic                       T_WR,
    input  logic                       T_RD,
    input  logic                       T_EN,
    output logic [IA_W-1:0]            T_DO,
    output logic                       T_RDY,
    output logic                       DONE_B,
    output logic [1:0]                 STATE,
    output logic                       IO_UPD,
    output logic [$clog2(Q_DEPTH):0]   Q_LVL,
    output logic                       OVF,
    output logic                       WDT_TRIP
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WDT_W = $clog2(WDT_MAX + 1);
    localparam int IO_W  = $clog2(IO_CYC + 1);

    localparam logic [LVL_W-1:0] Q_FULL   = LVL_W'(Q_DEPTH);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_MAX - 1);
    localparam logic [IO_W-1:0]  IO_LAST  = IO_W'(IO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_IO    = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IA_W-1:0]    r_mem [Q_DEPTH];
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [LVL_W-1:0]   r_lvl;
    logic [IA_W-1:0]    r_tdo;
    logic [WDT_W-1:0]   r_wdt;
    logic [IO_W-1:0]    r_io_cnt;
    logic               r_stop;
    logic               r_ovf, r_wdt_trip;

    logic w_push, w_pop, w_empty, w_full, w_run;
    logic w_eos, w_ovf_evt, w_wdt_evt, w_io_last, w_q_act, w_wr_en;

    assign w_push    = T_EN & T_WR;
    assign w_pop     = T_EN & T_RD;
    assign w_empty   = (r_lvl == '0);
    assign w_full    = (r_lvl == Q_FULL);
    assign w_run     = (r_state == S_RUN);
    assign w_eos     = w_run & w_pop & ~w_push & w_empty;
    assign w_ovf_evt = w_run & w_push & ~w_pop & w_full;
    assign w_wdt_evt = w_run & (r_wdt == WDT_LAST);
    assign w_io_last = (r_state == S_IO) && (r_io_cnt == IO_LAST);

    // Fault wins over end-of-scan when both land in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_wdt_evt || w_ovf_evt) w_state_nxt = S_FAULT;
                else if (w_eos)             w_state_nxt = S_IO;
            end
            S_IO:    if (w_io_last) w_state_nxt = (STOP || r_stop) ? S_IDLE : S_RUN;
            S_FAULT: if (FAULT_ACK) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Queue only moves while staying in RUN; any exit from RUN flushes it.
    assign w_q_act = w_run && (w_state_nxt == S_RUN);
    assign w_wr_en = w_q_act && w_push && (w_pop ? !w_empty : !w_full);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_head <= '0;
            r_tail <= '0;
            r_lvl  <= '0;
        end else if (!w_q_act) begin
            r_head <= '0;
            r_tail <= '0;
            r_lvl  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: if (!w_empty) begin
                    r_head <= r_head + 1'b1;
                    r_tail <= r_tail + 1'b1;
                end
                2'b10: if (!w_full) begin
                    r_tail <= r_tail + 1'b1;
                    r_lvl  <= r_lvl + 1'b1;
                end
                2'b01: if (!w_empty) begin
                    r_head <= r_head + 1'b1;
                    r_lvl  <= r_lvl - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[r_tail] <= T_DI;
    end

    // Empty-queue push+pop bypasses T_DI straight to the CPU.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_tdo <= '0;
        end else if (w_run && w_pop) begin
            if (!w_empty)    r_tdo <= r_mem[r_head];
            else if (w_push) r_tdo <= T_DI;
            else             r_tdo <= '0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_wdt    <= '0;
            r_io_cnt <= '0;
            r_stop   <= 1'b0;
        end else begin
            r_wdt    <= w_run ? r_wdt + 1'b1 : '0;
            r_io_cnt <= (r_state == S_IO) ? r_io_cnt + 1'b1 : '0;
            if (r_state == S_IDLE)  r_stop <= 1'b0;
            else if (w_run && STOP) r_stop <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_ovf      <= 1'b0;
            r_wdt_trip <= 1'b0;
        end else if (r_state == S_FAULT && FAULT_ACK) begin
            r_ovf      <= 1'b0;
            r_wdt_trip <= 1'b0;
        end else begin
            if (w_ovf_evt) r_ovf      <= 1'b1;
            if (w_wdt_evt) r_wdt_trip <= 1'b1;
        end
    end

    assign T_DO     = r_tdo;
    assign T_RDY    = w_q_act;
    assign DONE_B   = ~w_run;
    assign STATE    = r_state;
    assign IO_UPD   = (r_state == S_IO);
    assign Q_LVL    = r_lvl;
    assign OVF      = r_ovf;
    assign WDT_TRIP = r_wdt_trip;

endmodule

// File: doc/task_scheduler.md
Name: task_scheduler

Overview:
- Scan-cycle sequencer and task queue for bit_cpu; drives its STATE, DONE_B and T_I inputs, and consumes its T_O, T_WR, T_RD and T_EN outputs.
- ADD_TASK pushes a task start address into a circular FIFO. GET_TASK pops the next address for the CPU to jump to.
- A GET_TASK on an empty queue ends the scan. The block then runs an I/O update phase and restarts the program at address 0.
- A watchdog and a queue-overflow detector force a sticky FAULT state.

Parameters:
- IA_W, 12, task/instruction address width (matches bit_cpu IA_W).
- Q_DEPTH, 8, task FIFO entries; power of two, ≥2.
- IO_CYC, 4, cycles IO_UPD is held per I/O phase; ≥1.
- WDT_MAX, 4095, maximum cycles allowed in RUN per scan before FAULT.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous active-low reset.
- START  in  1  level; request scanning from IDLE.
- STOP  in  1  level; finish the current scan, then go to IDLE.
- FAULT_ACK  in  1  single-cycle; leave FAULT.
- T_DI  in  IA_W  task address from CPU T_O.
- T_WR  in  1  push request (CPU ADD_TASK, EXE stage).
- T_RD  in  1  pop request (CPU GET_TASK, DAT stage).
- T_EN  in  1  qualifier; T_WR/T_RD are ignored unless T_EN=1.
- T_DO  out  IA_W  popped task address to CPU T_I; registered.
- T_RDY  out  1  to CPU task-ready (D_RDY mux); 1 when a pop can be served this cycle.
- DONE_B  out  1  to CPU; holds IP.
- STATE  out  2  to CPU; 00 IDLE, 01 RUN, 10 IO, 11 FAULT.
- IO_UPD  out  1  high during the IO phase (image latch strobe).
- Q_LVL  out  clog2(Q_DEPTH)+1  current queue occupancy.
- OVF  out  1  sticky; a push was attempted while the queue was full.
- WDT_TRIP  out  1  sticky; watchdog expired.

Behaviour:
- Reset (CLR=0, asynchronous):
  - STATE=00, queue empty, Q_LVL=0, T_DO=0.
  - DONE_B=1, IO_UPD=0, OVF=0, WDT_TRIP=0, watchdog=0, stop latch=0.
- All other state changes happen on the rising edge of CLK.
- PUSH = T_EN&T_WR; POP = T_EN&T_RD. Both are acted on only in RUN and ignored in every other state.
- IDLE: DONE_B=1. START=1 → RUN; watchdog cleared; queue empty.
- RUN:
  - DONE_B=0. Watchdog increments every cycle.
  - Watchdog reaching WDT_MAX → FAULT; WDT_TRIP set.
- PUSH, queue not full: write T_DI at the tail; Q_LVL+1.
- PUSH, queue full: entry discarded; OVF set; → FAULT next cycle.
- POP, queue not empty: T_DO ← head on the next edge; head advances; Q_LVL−1.
  - T_RDY=1 in RUN except during the cycle the FSM leaves RUN.
  - T_DO is therefore valid when the CPU's GET_TASK reaches EXE.
- PUSH and POP in the same cycle:
  - Non-empty queue: pop the head and push T_DI; Q_LVL unchanged; full+pop+push is legal, no OVF.
  - Empty queue: bypass, T_DO ← T_DI; Q_LVL stays 0; the scan does not end.
- POP, queue empty, no PUSH: end of scan.
  - T_DO ← 0; DONE_B ← 1.
  - → IO next cycle. The CPU resets its IP because STATE≠01.
- Head/tail pointers wrap modulo Q_DEPTH. Q_LVL is never above Q_DEPTH.
- IO:
  - IO_UPD=1 and DONE_B=1 for exactly IO_CYC cycles; queue flushed on entry.
  - Then → IDLE if STOP is high or was latched during the scan; otherwise → RUN with the watchdog cleared.
- STOP is sampled every cycle in RUN and latched. The latch clears on entry to IDLE. STOP never aborts a scan mid-way.
- FAULT:
  - DONE_B=1, IO_UPD=0; queue flushed; pushes and pops ignored.
  - FAULT_ACK → IDLE; clears OVF and WDT_TRIP.
  - FAULT has priority over an end-of-scan event in the same cycle.
- START held high in IDLE when FAULT_ACK is given: FAULT → IDLE, then RUN on the next cycle. There is no direct FAULT→RUN transition.
- CLR asserted mid-scan or mid-IO: immediate return to the reset values; no IO phase.

Test Plan:
- Reset then START=1:
  - STATE 00→01 one cycle later; DONE_B falls to 0.
  - POP with empty queue → T_DO=0; STATE 01→10; IO_UPD high for 4 cycles; then STATE=01.
- PUSH 0x010, 0x020, then POP, POP:
  - T_DO=0x010, then 0x020; Q_LVL 2→1→0.
  - Third POP → STATE=10.
- Fill Q_DEPTH=8 entries, then a 9th PUSH:
  - OVF=1; STATE=11; Q_LVL=0.
  - FAULT_ACK → STATE=00; OVF=0.
- Wrap-around: 8 PUSHes, 8 POPs, 3 PUSHes (0x100–0x102), 3 POPs:
  - Values returned in order; Q_LVL=0.
  - Simultaneous PUSH 0x0AB and POP on the empty queue → T_DO=0x0AB; STATE stays 01.
- WDT_MAX=20 with no POPs: STATE=11 on cycle 20 of RUN; WDT_TRIP=1.
- STOP pulse during RUN: the scan completes, IO runs 4 cycles, then STATE=00.
- CLR low during IO: STATE=00 immediately, IO_UPD=0, DONE_B=1.
